// File: rtl/window_line_buffer.sv
// Streaming 3x3 window generator fed by an external pixel index counter.
// Optional WINDOW_FRAME_DONE_EN adds a one-cycle frame_done pulse after the last pixel.

`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 4
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 2
`endif
`ifndef INPUT_HEIGHT_LOG
`define INPUT_HEIGHT_LOG 2
`endif

module window_line_buffer #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = `INPUT_WIDTH,
  parameter int unsigned IMG_HEIGHT  = `INPUT_HEIGHT,
  parameter int unsigned WLOG        = `INPUT_WIDTH_LOG,
  parameter int unsigned HLOG        = `INPUT_HEIGHT_LOG
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel,
  input  logic [WLOG-1:0]          width_index,
  input  logic [HLOG-1:0]          height_index,
  output logic                     count_enable,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [9*PIXEL_WIDTH-1:0] win_pixels,
  output logic [WLOG-1:0]          win_col,
  output logic [HLOG-1:0]          win_row
`ifdef WINDOW_FRAME_DONE_EN
  ,
  output logic                     frame_done
`endif
);

  localparam int unsigned PW       = PIXEL_WIDTH;
  localparam int unsigned WIN_BITS = 9 * PIXEL_WIDTH;

  // A 3x3 window needs at least three rows and three columns.
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_cfg
    $error("window_line_buffer: image must be at least 3x3");
  end

  logic                accept;
  logic                emit;
  logic [PW-1:0]       top_c;
  logic [PW-1:0]       mid_c;
  logic [PW-1:0]       lb0 [IMG_WIDTH];
  logic [PW-1:0]       lb1 [IMG_WIDTH];
  logic [WIN_BITS-1:0] win_q;
  logic [WIN_BITS-1:0] win_shift;

  assign in_ready     = !win_valid || win_ready;
  assign count_enable = in_valid && in_ready;
  assign accept       = count_enable;
  assign emit         = accept && (height_index >= HLOG'(2)) && (width_index >= WLOG'(2));

  assign top_c = lb0[width_index];
  assign mid_c = lb1[width_index];

  // Left shift of the 3x3 register with the new column (row h-2, row h-1, row h) on the right.
  always_comb begin
    win_shift = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      win_shift[(3*r)*PW +: PW]   = win_q[(3*r+1)*PW +: PW];
      win_shift[(3*r+1)*PW +: PW] = win_q[(3*r+2)*PW +: PW];
    end
    win_shift[2*PW +: PW] = top_c;
    win_shift[5*PW +: PW] = mid_c;
    win_shift[8*PW +: PW] = in_pixel;
  end

  // Line buffers are plain storage; stale contents are never emitted.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb0[width_index] <= mid_c;
      lb1[width_index] <= in_pixel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_q      <= '0;
      win_valid  <= 1'b0;
      win_pixels <= '0;
      win_col    <= '0;
      win_row    <= '0;
    end else begin
      if (accept) begin
        win_q <= win_shift;
      end
      if (emit) begin
        win_valid  <= 1'b1;
        win_pixels <= win_shift;
        win_col    <= width_index - WLOG'(1);
        win_row    <= height_index - HLOG'(1);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef WINDOW_FRAME_DONE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && (width_index == WLOG'(IMG_WIDTH - 1))
                           && (height_index == HLOG'(IMG_HEIGHT - 1));
    end
  end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: 4x4 frames, pixel = base + 4h + w, image-array reference model.
module tb_window_line_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic [1:0]  cw;
  logic [1:0]  ch;
  logic        count_enable;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_pixels;
  logic [1:0]  win_col;
  logic [1:0]  win_row;
`ifdef WINDOW_FRAME_DONE_EN
  logic        frame_done;
`endif

  int base;
  int n_cmp;
  int n_err;

  window_line_buffer #(
    .PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .WLOG(2), .HLOG(2)
  ) dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .width_index(cw), .height_index(ch),
    .count_enable(count_enable), .win_valid(win_valid), .win_ready(win_ready),
    .win_pixels(win_pixels), .win_col(win_col), .win_row(win_row)
`ifdef WINDOW_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster index counter placed alongside the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw <= 2'd0;
      ch <= 2'd0;
    end else if (count_enable) begin
      if (cw == 2'(W - 1)) begin
        cw <= 2'd0;
        ch <= (ch == 2'(H - 1)) ? 2'd0 : ch + 2'd1;
      end else begin
        cw <= cw + 2'd1;
      end
    end
  end

  assign in_pixel = 8'(base + 4 * int'(ch) + int'(cw));

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a 2-D image; a window is the 3x3 block ending at the pixel
  int          img [H][W];
  logic        m_valid;
  logic [71:0] m_pix;
  logic [1:0]  m_col;
  logic [1:0]  m_row;
  logic        m_fd;
  int          acc_total;
  int          first_valid_acc;
  bit          seen_first;
  int          fd_pulses;

  typedef struct packed {
    logic [71:0] pix;
    logic [1:0]  col;
    logic [1:0]  row;
  } went_t;
  went_t wlog[$];

  initial begin
    seen_first      = 1'b0;
    first_valid_acc = -1;
    fd_pulses       = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid   = 1'b0;
      m_pix     = '0;
      m_col     = '0;
      m_row     = '0;
      m_fd      = 1'b0;
      acc_total = 0;
    end else begin
      logic acc;
      chk("in_ready", 72'(in_ready), 72'(!m_valid || win_ready));
      chk("count_enable", 72'(count_enable), 72'(in_valid && (!m_valid || win_ready)));
      chk("win_valid", 72'(win_valid), 72'(m_valid));
      if (m_valid) begin
        chk("win_pixels", win_pixels, m_pix);
        chk("win_col", 72'(win_col), 72'(m_col));
        chk("win_row", 72'(win_row), 72'(m_row));
      end
`ifdef WINDOW_FRAME_DONE_EN
      chk("frame_done", 72'(frame_done), 72'(m_fd));
      if (frame_done) begin
        fd_pulses++;
        chk("fd_after_last_accept", 72'(acc_total > 0 && acc_total % 16 == 0), 72'(1));
      end
`endif
      if (!seen_first && win_valid) begin
        seen_first      = 1'b1;
        first_valid_acc = acc_total;
      end
      if (win_valid && win_ready) wlog.push_back('{win_pixels, win_col, win_row});

      acc  = in_valid && (!m_valid || win_ready);
      m_fd = acc && (int'(cw) == W - 1) && (int'(ch) == H - 1);
      if (acc) begin
        acc_total++;
        img[ch][cw] = int'(in_pixel);
      end
      if (acc && ch >= 2'd2 && cw >= 2'd2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            m_pix[(3*r+c)*8 +: 8] = 8'(img[int'(ch)-2+r][int'(cw)-2+c]);
        m_col   = cw - 2'd1;
        m_row   = ch - 2'd1;
        m_valid = 1'b1;
      end else if (win_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // One frame of 16 accepts; optional gapped valid, backpressure on first window, reset abort
  task automatic run_frame(input int b, input bit gap, input bit bp, input bit abort);
    int acc_n = 0;
    int cyc   = 0;
    bit bp_done = 1'b0;
    logic [71:0] snap;
    logic [1:0]  snap_col;
    logic [1:0]  snap_row;
    while (acc_n < 16 && cyc < 200) begin
      @(posedge clk); #1;
      base      = b;
      in_valid  = gap ? (cyc % 2 == 0) : 1'b1;
      win_ready = 1'b1;
      if (bp && !bp_done && win_valid) begin
        win_ready = 1'b0;
        snap = win_pixels; snap_col = win_col; snap_row = win_row;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("bp_in_ready", 72'(in_ready), 72'(0));
          chk("bp_count_enable", 72'(count_enable), 72'(0));
          chk("bp_pixels_stable", win_pixels, snap);
          chk("bp_coord_stable", 72'({win_col, win_row}), 72'({snap_col, snap_row}));
          if (abort && i == 2) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_win_valid", 72'(win_valid), 72'(0));
            chk("rst_win_pixels", win_pixels, 72'(0));
            chk("rst_in_ready", 72'(in_ready), 72'(1));
            @(posedge clk); #1;
            in_valid  = 1'b0;
            win_ready = 1'b1;
            rst_n     = 1'b1;
            return;
          end
        end
        win_ready = 1'b1;
        bp_done   = 1'b1;
      end
      if (in_valid && (!win_valid || win_ready)) acc_n++;
      cyc++;
    end
    chk("frame_accepts", 72'(acc_n), 72'(16));
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    win_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input string name, input int idx, input logic [71:0] pix,
                         input logic [1:0] col, input logic [1:0] row);
    went_t e;
    e = wlog[idx];
    chk({name, "_pix"}, e.pix, pix);
    chk({name, "_coord"}, 72'({e.col, e.row}), 72'({col, row}));
  endtask

  localparam logic [71:0] FIRST_WIN = 72'h0A_09_08_06_05_04_02_01_00;
  localparam logic [71:0] LAST_WIN  = 72'h0F_0E_0D_0B_0A_09_07_06_05;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b1;
    base      = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_win_valid", 72'(win_valid), 72'(0));
    chk("reset_win_pixels", win_pixels, 72'(0));
    chk("reset_in_ready", 72'(in_ready), 72'(1));
    chk("reset_coord", 72'({win_col, win_row}), 72'(0));
`ifdef WINDOW_FRAME_DONE_EN
    chk("reset_frame_done", 72'(frame_done), 72'(0));
`endif
    rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0, 1'b0);    // full rate
    run_frame(0, 1'b0, 1'b1, 1'b0);    // backpressure on first window
    run_frame(0, 1'b1, 1'b0, 1'b0);    // gapped input
    run_frame(100, 1'b0, 1'b0, 1'b0);  // back-to-back second frame
    drain();
    run_frame(0, 1'b0, 1'b1, 1'b1);    // reset mid-frame
    run_frame(0, 1'b0, 1'b0, 1'b0);    // clean frame after reset
    drain();

    chk("first_valid_after_11th", 72'(first_valid_acc), 72'(11));
    chk("window_count", 72'(wlog.size()), 72'(20));
    if (wlog.size() == 20) begin
      chk_win("full_first", 0, FIRST_WIN, 2'd1, 2'd1);
      chk_win("full_last", 3, LAST_WIN, 2'd2, 2'd2);
      chk_win("bp_first", 4, FIRST_WIN, 2'd1, 2'd1);
      chk_win("bp_last", 7, LAST_WIN, 2'd2, 2'd2);
      chk_win("gap_first", 8, FIRST_WIN, 2'd1, 2'd1);
      chk_win("gap_last", 11, LAST_WIN, 2'd2, 2'd2);
      for (int k = 12; k < 16; k++)
        for (int j = 0; j < 9; j++) begin
          went_t e;
          e = wlog[k];
          chk("frame2_min", 72'(e.pix[j*8 +: 8] >= 8'd100), 72'(1));
        end
      chk_win("post_reset_first", 16, FIRST_WIN, 2'd1, 2'd1);
      chk_win("post_reset_last", 19, LAST_WIN, 2'd2, 2'd2);
    end
`ifdef WINDOW_FRAME_DONE_EN
    chk("frame_done_pulses", 72'(fd_pulses), 72'(5));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
